// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC select and the IF/ID pipeline register.
// Optional IF_PERF_CNT_EN adds stall_cnt / flush_cnt performance counters.
//
// state | meaning
// BOOT  | first edge after reset: fetch RESET_PC unconditionally, ignore stall/flush
// RUN   | normal fetch under hazard-unit stall and ID-stage redirect control
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_W     = 32,
  parameter int          INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              IF_ID_write,
  input  logic              flush,
  input  logic [1:0]        pc_src,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [PC_W-1:0]   jump_target,
  input  logic [PC_W-1:0]   jr_target,
  input  logic [INST_W-1:0] imem_inst,
  output logic [PC_W-1:0]   imem_addr,
  output logic [INST_W-1:0] if_id_inst,
  output logic [PC_W-1:0]   if_id_pc4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt,
`endif
  output logic              if_id_valid
);

  typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt, pc4;
  logic [INST_W-1:0] inst_nxt;
  logic [PC_W-1:0]   pc4_nxt;
  logic              valid_nxt;

  assign pc4       = pc + PC_W'(4);
  assign imem_addr = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= PC_W'(RESET_PC);
      if_id_inst  <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_inst  <= inst_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    inst_nxt  = if_id_inst;
    pc4_nxt   = if_id_pc4;
    valid_nxt = if_id_valid;
    case (state)
      BOOT: begin
        pc_nxt    = pc4;
        inst_nxt  = imem_inst;
        pc4_nxt   = pc4;
        valid_nxt = 1'b1;
        state_nxt = RUN;
      end
      default: begin
        // A stalled redirect is dropped; ID re-resolves it next cycle.
        if (pc_write) begin
          case (pc_src)
            2'b01:   pc_nxt = branch_target;
            2'b10:   pc_nxt = jump_target;
            2'b11:   pc_nxt = jr_target;
            default: pc_nxt = pc4;
          endcase
        end
        if (IF_ID_write) begin
          pc4_nxt = pc4;
          if (flush) begin
            inst_nxt  = '0;
            valid_nxt = 1'b0;
          end else begin
            inst_nxt  = imem_inst;
            valid_nxt = 1'b1;
          end
        end
      end
    endcase
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state == RUN) begin
      if (!pc_write)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && IF_ID_write)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage; instruction memory returns addr + 32'h1000.
// Counter checks are compiled in only when IF_PERF_CNT_EN is defined.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, IF_ID_write, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] imem_inst, imem_addr, if_id_inst, if_id_pc4;
  logic        if_id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .clk(clk), .rst(rst), .pc_write(pc_write), .IF_ID_write(IF_ID_write),
    .flush(flush), .pc_src(pc_src), .branch_target(branch_target),
    .jump_target(jump_target), .jr_target(jr_target), .imem_inst(imem_inst),
    .imem_addr(imem_addr), .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4),
`ifdef IF_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .if_id_valid(if_id_valid)
  );

  always #5 clk = ~clk;
  assign imem_inst = imem_addr + 32'h1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] pc4, input logic valid);
    chk({tag, ".pc"},    imem_addr, pc);
    chk({tag, ".inst"},  if_id_inst, inst);
    chk({tag, ".pc4"},   if_id_pc4, pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; pc_write = 1'b1; IF_ID_write = 1'b1; flush = 1'b0; pc_src = 2'b00;
    branch_target = 32'd40; jump_target = 32'h100; jr_target = 32'hFFFF_FFFC;
    #12;
    chk_all("reset", 32'd0, 32'd0, 32'd0, 1'b0);
    rst = 1'b0;

    step(); chk_all("boot", 32'd4, 32'h1000, 32'd4, 1'b1);
    step(); step(); step();
    chk_all("seq3", 32'd16, 32'h100C, 32'd16, 1'b1);

    pc_write = 1'b0; IF_ID_write = 1'b0; pc_src = 2'b01;
    step(); chk_all("stall1", 32'd16, 32'h100C, 32'd16, 1'b1);
    step(); chk_all("stall2", 32'd16, 32'h100C, 32'd16, 1'b1);
    pc_write = 1'b1; IF_ID_write = 1'b1;
    step(); chk_all("branch", 32'd40, 32'h1010, 32'd20, 1'b1);

    pc_src = 2'b10; flush = 1'b1;
    step(); chk_all("jflush", 32'h100, 32'd0, 32'd44, 1'b0);
    pc_src = 2'b00; flush = 1'b0;
    step(); chk_all("jtgt", 32'h104, 32'h1100, 32'h104, 1'b1);

    IF_ID_write = 1'b0; flush = 1'b1;
    step(); chk_all("ifid_hold", 32'h108, 32'h1100, 32'h104, 1'b1);
    IF_ID_write = 1'b1;
    step(); chk_all("seq_flush", 32'h10C, 32'd0, 32'h10C, 1'b0);

    flush = 1'b0; pc_write = 1'b0;
    step(); chk_all("pc_hold", 32'h10C, 32'h110C, 32'h110, 1'b1);

    pc_write = 1'b1; pc_src = 2'b11;
    step(); chk_all("jr", 32'hFFFF_FFFC, 32'h110C, 32'h110, 1'b1);
    pc_src = 2'b00;
    step(); chk_all("wrap", 32'd0, 32'h0000_0FFC, 32'd0, 1'b1);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt", stall_cnt, 32'd3);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif

    jr_target = 32'h200; pc_src = 2'b11;
    step(); chk_all("jr200", 32'h200, 32'h1000, 32'd4, 1'b1);
    pc_write = 1'b0; IF_ID_write = 1'b0;
    step();
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 32'd0, 32'd0, 32'd0, 1'b0);
`ifdef IF_PERF_CNT_EN
    chk("stall_cnt_rst", stall_cnt, 32'd0);
    chk("flush_cnt_rst", flush_cnt, 32'd0);
`endif
    #2 rst = 1'b0; flush = 1'b1; IF_ID_write = 1'b1;
    step(); chk_all("boot_ignores", 32'd4, 32'h1000, 32'd4, 1'b1);
    step(); chk_all("run_stall_flush", 32'd4, 32'd0, 32'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
